// File: rtl/genome_loader.sv
// Writer side of the logic-cell configuration interface: takes one 4-bit word per cell
// over valid/ready, then drives it on the shared RAM bus with setup, strobe and hold phases.
module genome_loader #(
    parameter int N_CELLS  = 16,
    parameter int ADDR_W   = 4,
    parameter int HOLD_CYC = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         cfg_data,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    output logic [3:0]         cell_ram,
    output logic [N_CELLS-1:0] cell_we,
    output logic [ADDR_W-1:0]  cell_addr,
    output logic               busy,
    output logic               done
);

    localparam int                HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_CELLS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SETUP   = 3'd2,
        STROBE  = 3'd3,
        RELEASE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t            state_r;
    logic [HOLD_W-1:0] hold_cnt_r;

    // Compare-based decode so an address wider than the cell count never indexes out of range.
    function automatic logic [N_CELLS-1:0] onehot(input logic [ADDR_W-1:0] addr);
        logic [N_CELLS-1:0] vec;
        vec = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            vec[i] = (addr == ADDR_W'(i));
        end
        return vec;
    endfunction

    // Load sequencer; every output is a register so cell_we cannot glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            hold_cnt_r <= '0;
            cfg_ready  <= 1'b0;
            cell_ram   <= 4'd0;
            cell_we    <= '0;
            cell_addr  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done    <= 1'b0;
                    cell_we <= '0;
                    if (start) begin
                        cell_addr <= '0;
                        busy      <= 1'b1;
                        cfg_ready <= 1'b1;
                        state_r   <= LOAD;
                    end else begin
                        cfg_ready <= 1'b0;
                    end
                end
                LOAD: begin
                    if (cfg_valid && cfg_ready) begin
                        cell_ram  <= cfg_data;
                        cfg_ready <= 1'b0;
                        state_r   <= SETUP;
                    end else begin
                        cfg_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    hold_cnt_r <= '0;
                    cell_we    <= onehot(cell_addr);
                    state_r    <= STROBE;
                end
                STROBE: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        cell_we <= '0;
                        state_r <= RELEASE;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                    end
                end
                RELEASE: begin
                    if (cell_addr == LAST_ADDR) begin
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        cell_addr <= cell_addr + ADDR_W'(1);
                        cfg_ready <= 1'b1;
                        state_r   <= LOAD;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    cfg_ready <= 1'b0;
                    cell_we   <= '0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_genome_loader.sv
// Directed bench for genome_loader: three instances (4 cells/hold 1, 4 cells/hold 3,
// 5 cells with a 3-bit address) checked against hand-computed cycle timelines.
module tb_genome_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int vectors     = 0;
    int miscompares = 0;

    logic       start_a = 1'b0, valid_a = 1'b0, ready_a, busy_a, done_a;
    logic [3:0] data_a = 4'd0, ram_a, we_a, addr_a;
    logic       start_b = 1'b0, valid_b = 1'b0, ready_b, busy_b, done_b;
    logic [3:0] data_b = 4'd0, ram_b, we_b, addr_b;
    logic       start_c = 1'b0, valid_c = 1'b0, ready_c, busy_c, done_c;
    logic [3:0] data_c = 4'd0, ram_c;
    logic [4:0] we_c;
    logic [2:0] addr_c;

    genome_loader #(.N_CELLS(4), .ADDR_W(4), .HOLD_CYC(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .cfg_data(data_a), .cfg_valid(valid_a),
        .cfg_ready(ready_a), .cell_ram(ram_a), .cell_we(we_a), .cell_addr(addr_a),
        .busy(busy_a), .done(done_a));
    genome_loader #(.N_CELLS(4), .ADDR_W(4), .HOLD_CYC(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .cfg_data(data_b), .cfg_valid(valid_b),
        .cfg_ready(ready_b), .cell_ram(ram_b), .cell_we(we_b), .cell_addr(addr_b),
        .busy(busy_b), .done(done_b));
    genome_loader #(.N_CELLS(5), .ADDR_W(3), .HOLD_CYC(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .cfg_data(data_c), .cfg_valid(valid_c),
        .cfg_ready(ready_c), .cell_ram(ram_c), .cell_we(we_c), .cell_addr(addr_c),
        .busy(busy_c), .done(done_c));

    // Cell models: each cell captures the RAM bus on the rising edge of its write-enable.
    logic [3:0] prev_we_a = 4'd0, prev_we_b = 4'd0, prev_ram_b = 4'd0;
    logic [4:0] prev_we_c = 5'd0;
    logic [3:0] cells_a [4];
    logic [3:0] cells_b [4];
    logic [3:0] cells_c [5];
    int rise_a = 0, multi_a = 0;
    int run_b = 0, pulses_b = 0, bad_len_b = 0, unstable_b = 0;
    int max_addr_c = 0, beyond_c = 0, multi_c = 0;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (we_a[i] && !prev_we_a[i]) cells_a[i] <= ram_a;
        if ((we_a & ~prev_we_a) != 4'd0) rise_a <= rise_a + 1;
        if ($countones(we_a) > 1) multi_a <= multi_a + 1;
        prev_we_a <= we_a;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (we_b[i] && !prev_we_b[i]) cells_b[i] <= ram_b;
        if ((we_b != 4'd0 || prev_we_b != 4'd0) && ram_b !== prev_ram_b) unstable_b <= unstable_b + 1;
        if (we_b != 4'd0) begin
            run_b <= run_b + 1;
        end else if (run_b != 0) begin
            pulses_b <= pulses_b + 1;
            if (run_b != 3) bad_len_b <= bad_len_b + 1;
            run_b <= 0;
        end
        prev_we_b  <= we_b;
        prev_ram_b <= ram_b;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) if (we_c[i] && !prev_we_c[i]) cells_c[i] <= ram_c;
        if (rst_n === 1'b1 && int'(addr_c) > max_addr_c) max_addr_c <= int'(addr_c);
        if (addr_c > 3'd4) beyond_c <= beyond_c + 1;
        if ($countones(we_c) > 1) multi_c <= multi_c + 1;
        prev_we_c <= we_c;
    end

    // 00 AND, 01 OR, 10 XOR, 11 NAND; bits [3:2] are ignored by the cell.
    function automatic logic cell_out(input logic [3:0] cfg, input logic [1:0] in);
        case (cfg[1:0])
            2'b00:   return in[0] & in[1];
            2'b01:   return in[0] | in[1];
            2'b10:   return in[0] ^ in[1];
            default: return ~(in[0] & in[1]);
        endcase
    endfunction

    logic [3:0] we_log [1:31];
    logic [3:0] ram_log [1:31];
    logic [3:0] addr_log [1:31];
    logic       ready_log [1:31];
    logic       done_log [1:31];
    logic       busy_log [1:31];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the cycle start is high; logs hold what instance A shows in cycles 1..31.
    task automatic load_a(input logic [15:0] words, input int gap_from, input int gap_to,
                          input int re1, input int re2);
        int   idx;
        logic hs;
        idx = 0;
        hs  = 1'b0;
        valid_a = 1'b1;
        data_a  = words[3:0];
        start_a = 1'b1;
        step();
        for (int c = 1; c < 32; c++) begin
            if (hs) idx++;
            we_log[c]    = we_a;
            ram_log[c]   = ram_a;
            addr_log[c]  = addr_a;
            ready_log[c] = ready_a;
            done_log[c]  = done_a;
            busy_log[c]  = busy_a;
            valid_a = !(c >= gap_from && c <= gap_to);
            data_a  = (idx < 4) ? words[idx*4 +: 4] : 4'h0;
            start_a = (c == re1 || c == re2);
            hs      = ready_a && valid_a;
            step();
        end
        valid_a = 1'b0;
        start_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        vectors++;
        if ({ready_a, ram_a, we_a, addr_a, busy_a, done_a} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_a got=%h exp=0", {ready_a, ram_a, we_a, addr_a, busy_a, done_a});
        end
        vectors++;
        if ({ready_b, ram_b, we_b, addr_b, busy_b, done_b} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_b got=%h exp=0", {ready_b, ram_b, we_b, addr_b, busy_b, done_b});
        end
        vectors++;
        if ({ready_c, ram_c, we_c, addr_c, busy_c, done_c} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_c got=%h exp=0", {ready_c, ram_c, we_c, addr_c, busy_c, done_c});
        end
        rst_n = 1'b1;
        repeat (2) step();
        vectors++;
        if ({ready_a, busy_a, we_a} !== 6'd0) begin
            miscompares++;
            $display("FAIL idle_after_reset got=%b exp=0", {ready_a, busy_a, we_a});
        end
    endtask

    task automatic test_reset_mid_strobe();
        int r0;
        valid_a = 1'b1;
        data_a  = 4'h5;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        step();
        step();
        vectors++;
        if (we_a !== 4'b0001) begin
            miscompares++;
            $display("FAIL strobe_before_reset got=%b exp=0001", we_a);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({we_a, busy_a, ready_a} !== 6'd0) begin
            miscompares++;
            $display("FAIL async_reset got=%b exp=000000", {we_a, busy_a, ready_a});
        end
        r0 = rise_a;
        repeat (3) step();
        rst_n   = 1'b1;
        valid_a = 1'b0;
        repeat (4) step();
        vectors++;
        if (rise_a !== r0) begin
            miscompares++;
            $display("FAIL no_we_edge_after_reset got=%0d exp=%0d", rise_a, r0);
        end
        vectors++;
        if ({we_a, busy_a, ready_a} !== 6'd0) begin
            miscompares++;
            $display("FAIL idle_after_release got=%b exp=000000", {we_a, busy_a, ready_a});
        end
    endtask

    task automatic test_basic_load();
        logic [15:0] w;
        logic [3:0]  exp_we;
        w = 16'h0321;
        load_a(w, -1, -1, -1, -1);
        for (int c = 1; c < 25; c++) begin
            exp_we = 4'd0;
            if (c >= 3 && c <= 15 && (c - 3) % 4 == 0) exp_we = 4'b0001 << ((c - 3) / 4);
            vectors++;
            if (we_log[c] !== exp_we) begin
                miscompares++;
                $display("FAIL basic_we c=%0d got=%b exp=%b", c, we_log[c], exp_we);
            end
            vectors++;
            if (done_log[c] !== (c == 17)) begin
                miscompares++;
                $display("FAIL basic_done c=%0d got=%b exp=%b", c, done_log[c], c == 17);
            end
            vectors++;
            if (busy_log[c] !== (c <= 17)) begin
                miscompares++;
                $display("FAIL basic_busy c=%0d got=%b exp=%b", c, busy_log[c], c <= 17);
            end
            vectors++;
            if (ready_log[c] !== (c <= 13 && (c - 1) % 4 == 0)) begin
                miscompares++;
                $display("FAIL basic_ready c=%0d got=%b", c, ready_log[c]);
            end
            if (exp_we != 4'd0) begin
                vectors++;
                if (ram_log[c] !== w[((c - 3) / 4) * 4 +: 4] || addr_log[c] !== 4'((c - 3) / 4)) begin
                    miscompares++;
                    $display("FAIL basic_ram_addr c=%0d got=%h/%0d exp=%h/%0d", c, ram_log[c],
                             addr_log[c], w[((c - 3) / 4) * 4 +: 4], (c - 3) / 4);
                end
            end
        end
        vectors++;
        if (addr_log[20] !== 4'd3) begin
            miscompares++;
            $display("FAIL basic_addr_hold got=%0d exp=3", addr_log[20]);
        end
        vectors++;
        if ({cells_a[3], cells_a[2], cells_a[1], cells_a[0]} !== w || multi_a !== 0) begin
            miscompares++;
            $display("FAIL basic_cells got=%h%h%h%h multi=%0d exp=%h multi=0", cells_a[3],
                     cells_a[2], cells_a[1], cells_a[0], multi_a, w);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] w;
        logic [3:0]  exp_we;
        int          sc [4];
        w  = 16'hF6A9;
        sc = '{3, 7, 16, 20};
        load_a(w, 9, 13, -1, -1);
        for (int c = 1; c < 28; c++) begin
            exp_we = 4'd0;
            for (int k = 0; k < 4; k++) if (c == sc[k]) exp_we = 4'b0001 << k;
            vectors++;
            if (we_log[c] !== exp_we) begin
                miscompares++;
                $display("FAIL bp_we c=%0d got=%b exp=%b", c, we_log[c], exp_we);
            end
            vectors++;
            if (done_log[c] !== (c == 22)) begin
                miscompares++;
                $display("FAIL bp_done c=%0d got=%b exp=%b", c, done_log[c], c == 22);
            end
            vectors++;
            if (ready_log[c] !== (c == 1 || c == 5 || (c >= 9 && c <= 14) || c == 18)) begin
                miscompares++;
                $display("FAIL bp_ready c=%0d got=%b", c, ready_log[c]);
            end
            if (c >= 9 && c <= 13) begin
                vectors++;
                if (addr_log[c] !== 4'd2) begin
                    miscompares++;
                    $display("FAIL bp_wait_addr c=%0d got=%0d exp=2", c, addr_log[c]);
                end
            end
        end
        vectors++;
        if ({cells_a[3], cells_a[2], cells_a[1], cells_a[0]} !== w) begin
            miscompares++;
            $display("FAIL bp_cells got=%h%h%h%h exp=%h", cells_a[3], cells_a[2], cells_a[1],
                     cells_a[0], w);
        end
    endtask

    task automatic test_start_while_busy();
        logic [15:0] w;
        int          r0, ndone;
        w  = 16'hB5C4;
        r0 = rise_a;
        load_a(w, -1, -1, 6, 17);
        ndone = 0;
        for (int c = 1; c < 32; c++) if (done_log[c] === 1'b1) ndone++;
        vectors++;
        if (ndone !== 1 || done_log[17] !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_done_count got=%0d/%b exp=1/1", ndone, done_log[17]);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (addr_log[3 + 4 * k] !== 4'(k) || we_log[3 + 4 * k] !== (4'b0001 << k)) begin
                miscompares++;
                $display("FAIL restart_addr k=%0d got=%0d/%b exp=%0d", k, addr_log[3 + 4 * k],
                         we_log[3 + 4 * k], k);
            end
        end
        for (int c = 18; c < 32; c++) begin
            vectors++;
            if (busy_log[c] !== 1'b0) begin
                miscompares++;
                $display("FAIL restart_busy c=%0d got=%b exp=0", c, busy_log[c]);
            end
        end
        vectors++;
        if (rise_a - r0 !== 4 || {cells_a[3], cells_a[2], cells_a[1], cells_a[0]} !== w) begin
            miscompares++;
            $display("FAIL restart_cells rises=%0d exp=4 got=%h%h%h%h exp=%h", rise_a - r0,
                     cells_a[3], cells_a[2], cells_a[1], cells_a[0], w);
        end
    endtask

    task automatic test_hold3();
        logic [15:0] w;
        int          idx, done_at, ndone;
        logic        hs;
        logic [3:0]  we5, we6;
        w = 16'h3783;
        idx = 0; hs = 1'b0; done_at = -1; ndone = 0; we5 = 4'd0; we6 = 4'd0;
        valid_b = 1'b1;
        data_b  = w[3:0];
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int c = 1; c < 30; c++) begin
            if (hs) idx++;
            if (done_b === 1'b1) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
            if (c == 5) we5 = we_b;
            if (c == 6) we6 = we_b;
            data_b = (idx < 4) ? w[idx*4 +: 4] : 4'h0;
            hs     = ready_b && valid_b;
            step();
        end
        valid_b = 1'b0;
        vectors++;
        if (done_at !== 25 || ndone !== 1) begin
            miscompares++;
            $display("FAIL hold3_done got=%0d/%0d exp=25/1", done_at, ndone);
        end
        vectors++;
        if (we5 !== 4'b0001 || we6 !== 4'b0000) begin
            miscompares++;
            $display("FAIL hold3_edge got=%b,%b exp=0001,0000", we5, we6);
        end
        vectors++;
        if (pulses_b !== 4 || bad_len_b !== 0) begin
            miscompares++;
            $display("FAIL hold3_pulses got=%0d bad=%0d exp=4 bad=0", pulses_b, bad_len_b);
        end
        vectors++;
        if (unstable_b !== 0) begin
            miscompares++;
            $display("FAIL hold3_ram_stable got=%0d exp=0", unstable_b);
        end
        vectors++;
        if ({cells_b[3], cells_b[2], cells_b[1], cells_b[0]} !== w) begin
            miscompares++;
            $display("FAIL hold3_cells got=%h%h%h%h exp=%h", cells_b[3], cells_b[2], cells_b[1],
                     cells_b[0], w);
        end
        vectors++;
        if ({cell_out(cells_b[0], 2'b11), cell_out(cells_b[1], 2'b11), cell_out(cells_b[3], 2'b11),
             cell_out(cells_b[0], 2'b01)} !== 4'b0101) begin
            miscompares++;
            $display("FAIL hold3_nand got=%b exp=0101", {cell_out(cells_b[0], 2'b11),
                     cell_out(cells_b[1], 2'b11), cell_out(cells_b[3], 2'b11),
                     cell_out(cells_b[0], 2'b01)});
        end
    endtask

    task automatic test_max_addr();
        logic [19:0] w;
        int          idx, done_at, ndone;
        logic        hs;
        logic [4:0]  we19;
        w = 20'h91234;
        idx = 0; hs = 1'b0; done_at = -1; ndone = 0; we19 = 5'd0;
        valid_c = 1'b1;
        data_c  = w[3:0];
        start_c = 1'b1;
        step();
        start_c = 1'b0;
        for (int c = 1; c < 28; c++) begin
            if (hs) idx++;
            if (done_c === 1'b1) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
            if (c == 19) we19 = we_c;
            data_c = (idx < 5) ? w[idx*4 +: 4] : 4'h0;
            hs     = ready_c && valid_c;
            step();
        end
        valid_c = 1'b0;
        vectors++;
        if (done_at !== 21 || ndone !== 1) begin
            miscompares++;
            $display("FAIL max_done got=%0d/%0d exp=21/1", done_at, ndone);
        end
        vectors++;
        if (max_addr_c !== 4 || beyond_c !== 0 || addr_c !== 3'd4) begin
            miscompares++;
            $display("FAIL max_addr got=%0d beyond=%0d final=%0d exp=4 0 4", max_addr_c,
                     beyond_c, addr_c);
        end
        vectors++;
        if (we19 !== 5'b10000 || multi_c !== 0) begin
            miscompares++;
            $display("FAIL max_we got=%b multi=%0d exp=10000 multi=0", we19, multi_c);
        end
        vectors++;
        if (cells_c[4] !== 4'h9 || cells_c[0] !== 4'h4) begin
            miscompares++;
            $display("FAIL max_cells got=%h,%h exp=9,4", cells_c[4], cells_c[0]);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_strobe();
        test_basic_load();
        test_backpressure();
        test_start_while_busy();
        test_hold3();
        test_max_addr();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
